gray_codec_pipe: RTL and testbench
==================================

GRAY_CODEC_PIPE -- requirements
Module: gray_codec_pipe

Interface
REQ-001: Parameter WIDTH, default 8, is the code word width; legal range 2..32.
REQ-002: Parameter DEPTH_LOG2 is fixed at 1; the result buffer holds 2 entries.
REQ-003: clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004: rst_n  input  1  is the synchronous, active-low reset, sampled on the clk rising edge.
REQ-005: in_valid  input  1  is high when an input transaction is offered.
REQ-006: in_ready  output  1  is high when the block accepts an input transaction.
REQ-007: in_data  input  WIDTH  is the operand.
REQ-008: in_op  input  2  selects the operation: 00 bin->gray, 01 gray->bin, 10 gray increment, 11 gray decrement.
REQ-009: out_valid  output  1  is high when out_data holds a result.
REQ-010: out_ready  input  1  is high when the consumer takes the result.
REQ-011: out_data  output  WIDTH  is the result at the buffer head.
REQ-012: out_op  output  2  is the in_op that produced the head result.

Function
REQ-013: An input is accepted on a clk edge with in_valid=1 and in_ready=1; an output is popped on a clk edge with out_valid=1 and out_ready=1.
REQ-014: Op 00 computes in_data ^ (in_data >> 1).
REQ-015: Op 01 computes a prefix XOR from the MSB, so bit i = XOR of in_data[WIDTH-1:i].
REQ-016: Op 10 computes gray(bin(in_data)+1) modulo 2^WIDTH; all-ones binary wraps to gray 0.
REQ-017: Op 11 computes gray(bin(in_data)-1) modulo 2^WIDTH; binary 0 wraps to gray of all-ones.
REQ-018: The result is computed combinationally and written into the buffer on acceptance; no arithmetic state survives between transactions.
REQ-019: Buffer states are EMPTY (0 entries), ONE (1 entry) and FULL (2 entries), ordered FIFO.
REQ-020: EMPTY + accept -> ONE; out_valid rises the cycle after acceptance, giving a latency of 1 cycle.
REQ-021: ONE + accept only -> FULL; ONE + pop only -> EMPTY; ONE + accept and pop on the same edge -> ONE, and the head becomes the new result.
REQ-022: FULL + pop -> ONE, and the second entry becomes the head.
REQ-023: In FULL, in_ready=0 and no accept is possible, so there is no same-edge accept in FULL.
REQ-024: in_ready = rst_n & (state != FULL); out_valid = (state != EMPTY).
REQ-025: out_data and out_op hold stable while out_valid=1 and out_ready=0.
REQ-026: With out_ready held high, the block sustains 1 transaction per cycle with no bubbles.
REQ-027: When out_valid=0, out_data and out_op hold their last value.

Reset
REQ-028: While rst_n=0 at a clk edge, the state goes to EMPTY, out_valid=0, out_data=0 and out_op=00, and both entries are cleared.
REQ-029: in_ready is 0 while rst_n=0, and in_valid is ignored during reset.
REQ-030: A reset asserted mid-operation, in ONE or FULL, discards buffered results with no pop reported.
REQ-031: After rst_n returns high, in_ready=1 combinationally and the first accept is possible on the next edge.

Configuration
REQ-032: With macro GRAY_PARITY_EN defined, the block adds output out_parity (1 bit), equal to the XOR of all out_data bits and stored alongside each entry; its reset value is 0.
REQ-033: Without GRAY_PARITY_EN, the out_parity port and its storage are absent, and all other behaviour is identical.

Verification (WIDTH=4)
REQ-034: Ops with out_ready=1: op00 0110 -> 0101; op01 0101 -> 0110; op01 1000 -> 1111; each result appears 1 cycle after accept.
REQ-035: Wrap-around: op10 1000 -> 0000; op11 0000 -> 1000; op10 0000 -> 0001; op11 0001 -> 0000.
REQ-036: Backpressure: out_ready=0, push 0001, 0010, 0011 (op00) -> in_ready=0 after the 2nd accept and the 3rd is held; raise out_ready -> pops 0001, 0011, then 0010 once the 3rd is accepted; order preserved and no loss.
REQ-037: Simultaneous events: in ONE with head 0001, accept 0100 op00 and pop on the same edge -> state ONE, out_data=0110.
REQ-038: Reset mid-operation: in FULL, assert rst_n=0 for 1 cycle -> out_valid=0, out_data=0000, in_ready=0 during reset and 1 after.
REQ-039: Full sweep: all 16 values through op00 then op01 yield the identity; with GRAY_PARITY_EN defined, out_parity matches the XOR of out_data for every result.

Source files
------------

// File: rtl/gray_codec_pipe_if.sv
// gray_codec_pipe_if
//   Valid/ready bundle between a producer, the gray_codec_pipe block and a
//   consumer.
//   Input side : in_valid, in_ready, in_data[WIDTH], in_op[2]
//   Output side: out_valid, out_ready, out_data[WIDTH], out_op[2]
//                out_parity (only when GRAY_PARITY_EN is defined)
//   Modports: slave  = the codec block
//             master = the environment (producer + consumer)
interface gray_codec_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_op;
`ifdef GRAY_PARITY_EN
    logic             out_parity;
`endif

    modport slave (
        input  in_valid, in_data, in_op, out_ready,
        output in_ready, out_valid, out_data, out_op
`ifdef GRAY_PARITY_EN
        , output out_parity
`endif
    );

    modport master (
        output in_valid, in_data, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_op
`ifdef GRAY_PARITY_EN
        , input out_parity
`endif
    );
endinterface

// File: rtl/gray_codec_pipe.sv
// gray_codec_pipe
//   Gray-code codec with a 2-entry FIFO result buffer.
//   Ops: 00 bin->gray, 01 gray->bin, 10 gray increment, 11 gray decrement.
//   Ports:
//     clk   - single clock, rising edge
//     rst_n - synchronous active-low reset
//     bus   - gray_codec_pipe_if.slave (in_* accept side, out_* result side)
//   Optional feature macro: GRAY_PARITY_EN adds out_parity (XOR of out_data),
//   stored per buffer entry.
module gray_codec_pipe #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    gray_codec_pipe_if.slave    bus
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("gray_codec_pipe: WIDTH must be in 2..32");
    end
    if (DEPTH_LOG2 != 1) begin : g_bad_depth
        $error("gray_codec_pipe: DEPTH_LOG2 must be 1");
    end

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
    logic [1:0]       op0_q, op0_d, op1_q, op1_d;
`ifdef GRAY_PARITY_EN
    logic             par0_q, par0_d, par1_q, par1_d;
`endif
    logic [WIDTH-1:0] result;
    logic             acc, pop;

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down.
    function automatic logic [WIDTH-1:0] to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int unsigned i = WIDTH - 1; i > 0; i--) begin
            b[i-1] = b[i] ^ g[i-1];
        end
        return b;
    endfunction

    always_comb begin
        result = '0;
        case (bus.in_op)
            2'b00:   result = to_gray(bus.in_data);
            2'b01:   result = to_bin(bus.in_data);
            2'b10:   result = to_gray(to_bin(bus.in_data) + 1'b1);
            default: result = to_gray(to_bin(bus.in_data) - 1'b1);
        endcase
    end

    assign bus.in_ready  = rst_n & (state_q != FULL);
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.out_data  = data0_q;
    assign bus.out_op    = op0_q;
`ifdef GRAY_PARITY_EN
    assign bus.out_parity = par0_q;
`endif

    assign acc = bus.in_valid & bus.in_ready;
    assign pop = bus.out_valid & bus.out_ready;

    // Entry 0 is always the head; entry 1 is only meaningful in FULL.
    always_comb begin
        state_d = state_q;
        data0_d = data0_q;
        op0_d   = op0_q;
        data1_d = data1_q;
        op1_d   = op1_q;
`ifdef GRAY_PARITY_EN
        par0_d  = par0_q;
        par1_d  = par1_q;
`endif
        case (state_q)
            EMPTY: begin
                if (acc) begin
                    state_d = ONE;
                    data0_d = result;
                    op0_d   = bus.in_op;
`ifdef GRAY_PARITY_EN
                    par0_d  = ^result;
`endif
                end
            end
            ONE: begin
                if (acc && pop) begin
                    data0_d = result;
                    op0_d   = bus.in_op;
`ifdef GRAY_PARITY_EN
                    par0_d  = ^result;
`endif
                end else if (acc) begin
                    state_d = FULL;
                    data1_d = result;
                    op1_d   = bus.in_op;
`ifdef GRAY_PARITY_EN
                    par1_d  = ^result;
`endif
                end else if (pop) begin
                    // Head register keeps its value so out_data holds while empty.
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d = ONE;
                    data0_d = data1_q;
                    op0_d   = op1_q;
`ifdef GRAY_PARITY_EN
                    par0_d  = par1_q;
`endif
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data0_q <= '0;
            op0_q   <= '0;
            data1_q <= '0;
            op1_q   <= '0;
`ifdef GRAY_PARITY_EN
            par0_q  <= 1'b0;
            par1_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data0_q <= data0_d;
            op0_q   <= op0_d;
            data1_q <= data1_d;
            op1_q   <= op1_d;
`ifdef GRAY_PARITY_EN
            par0_q  <= par0_d;
            par1_q  <= par1_d;
`endif
        end
    end

endmodule

// File: tb/tb_gray_codec_pipe.sv
// tb_gray_codec_pipe
//   Self-checking bench for gray_codec_pipe at WIDTH=4: directed vectors,
//   backpressure, same-edge accept/pop, mid-operation reset, full sweep and
//   randomized traffic, all against a queue-based reference model.
module tb_gray_codec_pipe;

    localparam int unsigned W    = 4;
    localparam int          NVAL = 1 << W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gray_codec_pipe_if #(.WIDTH(W)) bus ();

    gray_codec_pipe #(.WIDTH(W), .DEPTH_LOG2(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        int data;
        int op;
    } ent_t;

    ent_t q[$];
    int   last_data = 0;
    int   last_op   = 0;
    int   n_vec     = 0;
    int   n_err     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int gray(input int b);
        return (b ^ (b >> 1)) & (NVAL - 1);
    endfunction

    // Inverse by search over the code space: the value whose gray code is g.
    function automatic int ungray(input int g);
        for (int b = 0; b < NVAL; b++) begin
            if (gray(b) == g) return b;
        end
        return -1;
    endfunction

    function automatic int ref_op(input int op, input int x);
        case (op)
            0:       return gray(x);
            1:       return ungray(x);
            2:       return gray((ungray(x) + 1) % NVAL);
            default: return gray((ungray(x) + NVAL - 1) % NVAL);
        endcase
    endfunction

    // One clock cycle: drive at negedge, check current outputs, update model at posedge.
    task automatic step(input bit v, input int op, input int d, input bit ordy, input bit rn);
        int  exp_data;
        int  exp_op;
        bit  acc;
        bit  pop;
        @(negedge clk);
        rst_n         = rn;
        bus.in_valid  = v;
        bus.in_op     = op[1:0];
        bus.in_data   = d[W-1:0];
        bus.out_ready = ordy;
        #1;
        exp_data = (q.size() != 0) ? q[0].data : last_data;
        exp_op   = (q.size() != 0) ? q[0].op   : last_op;
        check("in_ready",  32'(bus.in_ready),  32'(rn && q.size() < 2));
        check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        check("out_data",  32'(bus.out_data),  32'(exp_data));
        check("out_op",    32'(bus.out_op),    32'(exp_op));
`ifdef GRAY_PARITY_EN
        check("out_parity", 32'(bus.out_parity), 32'($countones(exp_data) & 1));
`endif
        acc = v && rn && (q.size() < 2);
        pop = rn && (q.size() != 0) && ordy;
        @(posedge clk);
        if (!rn) begin
            q.delete();
            last_data = 0;
            last_op   = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back('{ref_op(op, d), op});
            if (q.size() != 0) begin
                last_data = q[0].data;
                last_op   = q[0].op;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b1, 1'b1);
    endtask

    int dir_op  [7] = '{0, 1, 1, 2, 3, 2, 3};
    int dir_in  [7] = '{4'b0110, 4'b0101, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0001};
    int dir_exp [7] = '{4'b0101, 4'b0110, 4'b1111, 4'b0000, 4'b1000, 4'b0001, 4'b0000};

    initial begin
        int g;
        bus.in_valid  = 1'b0;
        bus.in_op     = 2'b00;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state, with in_valid asserted and ignored.
        step(1'b1, 0, 5, 1'b1, 1'b0);
        step(1'b1, 0, 5, 1'b1, 1'b0);

        // Directed ops and wrap-around, one-cycle latency.
        for (int i = 0; i < 7; i++) begin
            step(1'b1, dir_op[i], dir_in[i], 1'b1, 1'b1);
            #2;
            check("dir_valid", 32'(bus.out_valid), 32'd1);
            check("dir_data",  32'(bus.out_data),  32'(dir_exp[i]));
        end
        drain();

        // Backpressure: third push held until a pop frees a slot.
        step(1'b1, 0, 1, 1'b0, 1'b1);
        step(1'b1, 0, 2, 1'b0, 1'b1);
        #2;
        check("bp_ready", 32'(bus.in_ready), 32'd0);
        step(1'b1, 0, 3, 1'b0, 1'b1);
        step(1'b1, 0, 3, 1'b1, 1'b1);
        step(1'b1, 0, 3, 1'b1, 1'b1);
        step(1'b0, 0, 0, 1'b1, 1'b1);
        drain();

        // Same-edge accept and pop in ONE.
        step(1'b1, 0, 1, 1'b0, 1'b1);
        step(1'b1, 0, 4, 1'b1, 1'b1);
        #2;
        check("simul_data",  32'(bus.out_data),  32'(4'b0110));
        check("simul_valid", 32'(bus.out_valid), 32'd1);
        drain();

        // Reset while FULL.
        step(1'b1, 0, 5, 1'b0, 1'b1);
        step(1'b1, 0, 6, 1'b0, 1'b1);
        step(1'b1, 0, 7, 1'b0, 1'b0);
        #2;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data",  32'(bus.out_data),  32'd0);
        check("rst_ready", 32'(bus.in_ready),  32'd0);
        step(1'b0, 0, 0, 1'b1, 1'b1);

        // Full sweep: bin->gray then gray->bin returns the original value.
        for (int v = 0; v < NVAL; v++) begin
            step(1'b1, 0, v, 1'b1, 1'b1);
            #2;
            g = int'(bus.out_data);
            step(1'b1, 1, g, 1'b1, 1'b1);
            #2;
            check("sweep", 32'(bus.out_data), 32'(v));
        end
        drain();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, NVAL - 1)), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 49) != 0));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
